// File: rtl/display_tx_buf.sv
// rtl/display_tx_buf.sv - CPU character FIFO feeding an 8N1 UART transmitter.
// Optional macro DISP_CRLF_EN expands an LF write into CR followed by LF.
module display_tx_buf #(
    parameter int DEPTH        = 16,
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       DISP_write_en,
    input  logic [6:0] DISP_data,
    input  logic       DISP_clear,
    output logic       DISP_status,
    output logic       buf_empty,
    output logic       buf_full,
    output logic       tx_busy,
    output logic       tx_out
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int TW = $clog2(CLKS_PER_BIT);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_STOP  = 2'd3;

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [CW-1:0] count;

    logic [1:0]    state;
    logic [TW-1:0] timer;
    logic [2:0]    bit_idx;
    logic [7:0]    shift;

    logic          push;
    logic          pop;
    logic [7:0]    push_data;
    logic          bit_done;

    assign buf_empty = (count == '0);
    assign buf_full  = (count == CW'(DEPTH));
    assign tx_busy   = (state != S_IDLE);
    assign bit_done  = (timer == TW'(CLKS_PER_BIT - 1));

    // A software clear outranks the serializer's pop so nothing starts from a flushed FIFO.
    assign pop = (state == S_IDLE) && !buf_empty && !DISP_clear;

`ifdef DISP_CRLF_EN
    logic lf_pending;
    logic lf_accept;
    logic two_free;

    assign two_free    = (count <= CW'(DEPTH - 2));
    assign DISP_status = !lf_pending && two_free;

    // The LF write reserves two slots up front, so the deferred LF push always fits.
    always_comb begin
        push      = 1'b0;
        push_data = {1'b0, DISP_data};
        lf_accept = 1'b0;
        if (!DISP_clear) begin
            if (lf_pending) begin
                push      = 1'b1;
                push_data = 8'h0A;
            end else if (DISP_write_en) begin
                if (DISP_data == 7'h0A) begin
                    if (two_free) begin
                        push      = 1'b1;
                        push_data = 8'h0D;
                        lf_accept = 1'b1;
                    end
                end else if (!buf_full || pop) begin
                    push = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset || DISP_clear) begin
            lf_pending <= 1'b0;
        end else begin
            lf_pending <= lf_accept;
        end
    end
`else
    assign push        = DISP_write_en && !DISP_clear && (!buf_full || pop);
    assign push_data   = {1'b0, DISP_data};
    assign DISP_status = !buf_full;
`endif

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || DISP_clear) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // tx_out is loaded with the level of the state being entered, keeping the line registered.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= S_IDLE;
            timer   <= '0;
            bit_idx <= '0;
            shift   <= '0;
            tx_out  <= 1'b1;
        end else begin
            case (state)
                S_IDLE: begin
                    tx_out <= 1'b1;
                    if (pop) begin
                        shift  <= mem[rd_ptr];
                        state  <= S_START;
                        timer  <= '0;
                        tx_out <= 1'b0;
                    end
                end
                S_START: begin
                    if (bit_done) begin
                        state   <= S_DATA;
                        timer   <= '0;
                        bit_idx <= '0;
                        tx_out  <= shift[0];
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                S_DATA: begin
                    if (bit_done) begin
                        timer <= '0;
                        if (bit_idx == 3'd7) begin
                            state  <= S_STOP;
                            tx_out <= 1'b1;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                            tx_out  <= shift[bit_idx + 3'd1];
                        end
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                S_STOP: begin
                    if (bit_done) begin
                        state  <= S_IDLE;
                        timer  <= '0;
                        tx_out <= 1'b1;
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                default: begin
                    state  <= S_IDLE;
                    timer  <= '0;
                    tx_out <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_display_tx_buf.sv
// tb/tb_display_tx_buf.sv - directed and random stimulus against a queue/timeline model of display_tx_buf.
module tb_display_tx_buf;

    localparam int DEPTH = 4;
    localparam int CPB   = 4;
    localparam int FRAME = 10 * CPB;

    logic       clk = 1'b0;
    logic       reset;
    logic       we;
    logic [6:0] data;
    logic       clr;
    logic       disp_status;
    logic       buf_empty;
    logic       buf_full;
    logic       tx_busy;
    logic       tx_out;

    int checks   = 0;
    int failures = 0;

    logic [7:0] q[$];
    int         busy_cnt = 0;
    logic [7:0] cur      = 8'h00;
    bit         pending  = 1'b0;

    display_tx_buf #(.DEPTH(DEPTH), .CLKS_PER_BIT(CPB)) dut (
        .clk          (clk),
        .reset        (reset),
        .DISP_write_en(we),
        .DISP_data    (data),
        .DISP_clear   (clr),
        .DISP_status  (disp_status),
        .buf_empty    (buf_empty),
        .buf_full     (buf_full),
        .tx_busy      (tx_busy),
        .tx_out       (tx_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Model: the FIFO is a queue; the serializer is a countdown over a 10-bit frame.
    task automatic model_edge(input logic r, input logic w, input logic [6:0] d, input logic c);
        int         sz;
        bit         do_pop;
        bit         do_push;
        bit         set_pend;
        logic [7:0] pv;
        if (r) begin
            q.delete();
            busy_cnt = 0;
            pending  = 1'b0;
            return;
        end
        sz       = q.size();
        do_pop   = (busy_cnt == 0) && (sz > 0) && !c;
        do_push  = 1'b0;
        set_pend = 1'b0;
        pv       = {1'b0, d};
`ifdef DISP_CRLF_EN
        if (pending) begin
            do_push = 1'b1;
            pv      = 8'h0A;
        end else if (w && d == 7'h0A) begin
            if (DEPTH - sz >= 2) begin
                do_push  = 1'b1;
                pv       = 8'h0D;
                set_pend = 1'b1;
            end
        end else if (w && (sz < DEPTH || do_pop)) begin
            do_push = 1'b1;
        end
`else
        do_push = w && (sz < DEPTH || do_pop);
`endif
        if (busy_cnt > 0) busy_cnt--;
        if (c) begin
            q.delete();
            pending = 1'b0;
        end else begin
            if (do_pop) begin
                cur      = q.pop_front();
                busy_cnt = FRAME;
            end
            if (do_push) q.push_back(pv);
            pending = set_pend;
        end
    endtask

    task automatic compare_all();
        int   p;
        int   b;
        logic exp_tx;
        logic exp_status;
        exp_tx = 1'b1;
        if (busy_cnt > 0) begin
            p = FRAME - busy_cnt;
            b = p / CPB;
            if (b == 0)      exp_tx = 1'b0;
            else if (b == 9) exp_tx = 1'b1;
            else             exp_tx = cur[b-1];
        end
`ifdef DISP_CRLF_EN
        exp_status = !pending && (DEPTH - q.size() >= 2);
`else
        exp_status = (q.size() != DEPTH);
`endif
        chk("tx_out",      tx_out,      exp_tx);
        chk("tx_busy",     tx_busy,     busy_cnt > 0);
        chk("buf_empty",   buf_empty,   q.size() == 0);
        chk("buf_full",    buf_full,    q.size() == DEPTH);
        chk("DISP_status", disp_status, exp_status);
    endtask

    task automatic step(input logic r, input logic w, input logic [6:0] d, input logic c);
        reset = r;
        we    = w;
        data  = d;
        clr   = c;
        @(posedge clk);
        model_edge(r, w, d, c);
        #1;
        compare_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 7'h00, 1'b0);
    endtask

    initial begin
        logic [6:0] hello [11];
        logic       rr;
        logic       ww;
        logic       cc;
        logic [6:0] dd;
        hello = '{7'h68, 7'h65, 7'h6C, 7'h6C, 7'h6F, 7'h20, 7'h77, 7'h6F, 7'h72, 7'h6C, 7'h64};
        reset = 1'b1;
        we    = 1'b0;
        data  = 7'h00;
        clr   = 1'b0;

        step(1'b1, 1'b0, 7'h00, 1'b0);
        step(1'b1, 1'b0, 7'h00, 1'b0);
        chk("reset_tx_out",    tx_out,      1'b1);
        chk("reset_tx_busy",   tx_busy,     1'b0);
        chk("reset_buf_empty", buf_empty,   1'b1);
        chk("reset_status",    disp_status, 1'b1);
        idle(3);

        // Single 'h' frame
        step(1'b0, 1'b1, 7'h68, 1'b0);
        step(1'b0, 1'b0, 7'h00, 1'b0);
        chk("h_start_bit", tx_out, 1'b0);
        idle(FRAME + 5);

        // "hello world" back to back; the shallow FIFO drops what does not fit
        for (int i = 0; i < 11; i++) step(1'b0, 1'b1, hello[i], 1'b0);
        idle(6 * (FRAME + 1));

        // Six-write burst into DEPTH=4 while the first frame starts
        for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 7'(7'h41 + i), 1'b0);
        chk("burst_full",   buf_full,    1'b1);
        chk("burst_status", disp_status, 1'b0);
        idle(5 * (FRAME + 1));

        // Clear during the data bits of 'e'
        step(1'b0, 1'b1, 7'h65, 1'b0);
        step(1'b0, 1'b1, 7'h6C, 1'b0);
        idle(10);
        step(1'b0, 1'b0, 7'h00, 1'b1);
        chk("clear_empty", buf_empty, 1'b1);
        idle(2 * FRAME);

        // Reset in the middle of a frame, then a clean '!'
        step(1'b0, 1'b1, 7'h55, 1'b0);
        idle(15);
        step(1'b1, 1'b0, 7'h00, 1'b0);
        chk("midreset_tx_out",  tx_out,  1'b1);
        chk("midreset_tx_busy", tx_busy, 1'b0);
        step(1'b0, 1'b1, 7'h21, 1'b0);
        idle(FRAME + 3);

        // LF write: CR/LF pair with the option, plain LF without
        step(1'b0, 1'b1, 7'h0A, 1'b0);
        idle(2 * FRAME + 4);

        // Random traffic
        for (int i = 0; i < 4000; i++) begin
            rr = ($urandom_range(0, 999) < 3);
            ww = ($urandom_range(0, 99) < 30);
            cc = ($urandom_range(0, 99) < 1);
            dd = ($urandom_range(0, 7) == 0) ? 7'h0A : 7'($urandom);
            step(rr, ww, dd, cc);
        end
        idle(DEPTH * (FRAME + 1) + FRAME + 4);
        chk("final_empty", buf_empty, 1'b1);
        chk("final_idle",  tx_busy,   1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/display_tx_buf.md
Name: display_tx_buf

Overview:
Output-side counterpart of the keyboard input buffer. The CPU writes 7-bit ASCII characters into a small FIFO, and the block serializes them onto a UART transmit line (8N1, LSB first). It sits between the CPU I/O-mapped display/terminal port and the board's serial TX pin. It exposes a status bit so software can poll for free space before writing.

Parameters:
DEPTH, 16, FIFO entries; power of two, minimum 4
CLKS_PER_BIT, 868, clk cycles per serial bit (100 MHz / 115200); minimum 2

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
DISP_write_en  input  1  one-cycle strobe: push DISP_data into FIFO
DISP_data  input  7  ASCII character to send
DISP_clear  input  1  synchronous FIFO flush (software clear)
DISP_status  output  1  1 = FIFO can accept a write
buf_empty  output  1  1 = FIFO holds no characters
buf_full  output  1  1 = FIFO holds DEPTH characters
tx_busy  output  1  1 = serializer not in IDLE
tx_out  output  1  serial line, idle high

Behaviour:
- Reset (synchronous, active-high): FIFO pointers and count = 0; FSM = IDLE; tx_out=1, tx_busy=0, buf_empty=1, buf_full=0, DISP_status=1. An in-flight frame is aborted; the line returns high on the next edge.
- FIFO: read and write pointers are log2(DEPTH) bits and wrap modulo DEPTH. Count ranges 0..DEPTH. The stored byte is {1'b0, DISP_data}.
- Write: on DISP_write_en with buf_full=0, the character is pushed and visible next cycle. A write while full is silently dropped; FIFO contents are unchanged.
- Pop: occurs only on the IDLE->START transition. A simultaneous push and pop in one cycle is legal; count is unchanged. A write to a full FIFO in the same cycle as a pop is accepted.
- DISP_clear: flushes the FIFO (pointers and count = 0) the next cycle. The frame currently being shifted completes normally. If DISP_clear and DISP_write_en occur in the same cycle, clear wins and the write is dropped. DISP_clear has priority over a pop in the same cycle.
- Serializer FSM:
  - IDLE: tx_out=1. If buf_empty=0, pop the head into the shift register and go to START.
  - START: tx_out=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
  - DATA: tx_out=shift[idx] for CLKS_PER_BIT cycles per bit, LSB first. After bit 7 go to STOP.
  - STOP: tx_out=1 for CLKS_PER_BIT cycles, then go to IDLE.
- The bit timer counts 0..CLKS_PER_BIT-1 and is cleared on every state or bit change.
- Latency: the start bit appears on tx_out 1 cycle after the FIFO becomes non-empty in IDLE. A frame is 10*CLKS_PER_BIT cycles. Back-to-back frames have exactly one IDLE cycle between the stop bit and the next start bit.
- tx_busy=1 in START, DATA and STOP.
- DISP_status = ~buf_full, combinational from registered count.
- tx_out is registered, so the line is glitch-free.

Optional Feature:
DISP_CRLF_EN
- Defined: a write of 0x0A (LF) pushes 0x0D then 0x0A in two consecutive cycles, using an internal pending-LF register. While the LF is pending, DISP_status=0 and further writes are dropped. DISP_status=0 whenever fewer than 2 slots are free, and an LF write with fewer than 2 free slots is dropped entirely. DISP_clear or reset cancels the pending LF.
- Undefined: 0x0A is stored as a single entry like any other character, and DISP_status = ~buf_full.

Test Plan:
- Reset, then write 0x68 ('h'), CLKS_PER_BIT=4 -> tx_out low at cycle+1 for 4 cycles, then bits 0,0,0,1,0,1,1,0 at 4 cycles each, then high for 4. tx_busy high for 40 cycles. buf_empty back to 1 after the pop.
- Write "hello world" (11 chars, 0x68..0x64) in consecutive cycles, DEPTH=16 -> 11 frames in order, each separated by exactly one idle cycle. No loss.
- DEPTH=4, 6 back-to-back writes 0x41..0x46 while the first frame starts -> 0x41 is popped, 0x42..0x45 stored, buf_full=1, DISP_status=0. 0x46 is dropped. Output is 0x41..0x45.
- Write 0x65 and 0x6C, then assert DISP_clear during the 'e' data bits -> 'e' frame completes, 'l' is never sent, buf_empty=1, FSM returns to IDLE.
- Assert reset mid-DATA -> tx_out=1, tx_busy=0, buf_empty=1 the next cycle. A following write of 0x21 yields a clean frame.
- With DISP_CRLF_EN, write 0x0A -> frames 0x0D then 0x0A are sent. DISP_status=0 during the pending cycle.
